bpf_pktbuf_ctrl: RTL and testbench

Single-packet buffer and handoff controller on the memory side of the BPF CPU control FSM. It accepts a packet from the snooper, then presents it to the CPU with `mem_ready` and single-cycle, byte-addressed, big-endian reads of any alignment. On the CPU's `accept` it hands the packet to the forwarder; on `reject` it drops the packet. It then returns to loading.

---
 rtl/bpf_defs_pkg.sv | 25 ++
 rtl/pktbuf_bank.sv | 30 +++
 rtl/bpf_pktbuf_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_bpf_pktbuf_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpf_defs_pkg.sv
// Shared encodings for the BPF packet buffer: read transfer sizes and buffer states.
package bpf_defs;

    typedef enum logic [1:0] {
        BPF_W = 2'b00,
        BPF_H = 2'b01,
        BPF_B = 2'b10
    } bpf_sz_e;

    typedef enum logic [1:0] {
        PB_LOAD = 2'd0,
        PB_RUN  = 2'd1,
        PB_FWD  = 2'd2
    } pb_state_e;

    // Size code 11 is deliberately folded into the byte case.
    function automatic logic [2:0] xfer_nbytes(input logic [1:0] sz);
        case (sz)
            BPF_W:   return 3'd4;
            BPF_H:   return 3'd2;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/pktbuf_bank.sv
// One bank of the packet buffer: single write port, registered CPU and forwarder read ports.
module pktbuf_bank #(
    parameter int IDX_W = 9
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic             cpu_rd_en,
    input  logic [IDX_W-1:0] cpu_rd_idx,
    output logic [31:0]      cpu_rd_data,
    input  logic [IDX_W-1:0] fwd_rd_idx,
    output logic [31:0]      fwd_rd_data
);

    logic [31:0] mem [0:(1<<IDX_W)-1];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_idx] <= wr_data;
    end

    // Reads sample the array before this cycle's write lands (read-old behaviour).
    always_ff @(posedge clk) begin
        if (cpu_rd_en)
            cpu_rd_data <= mem[cpu_rd_idx];
        fwd_rd_data <= mem[fwd_rd_idx];
    end

endmodule

// File: rtl/bpf_pktbuf_ctrl.sv
// Packet buffer and handoff controller: LOAD from snooper, RUN for CPU reads, FWD to forwarder.
import bpf_defs::*;

module bpf_pktbuf_ctrl #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  snp_ready,
    input  logic                  snp_wr_en,
    input  logic [ADDR_WIDTH-1:0] snp_wr_addr,
    input  logic [31:0]           snp_wr_data,
    input  logic                  snp_done,
    input  logic [ADDR_WIDTH+2:0] snp_len,
    output logic                  mem_ready,
    input  logic                  cpu_rd_en,
    input  logic [ADDR_WIDTH+1:0] cpu_byte_addr,
    input  logic [1:0]            transfer_sz,
    output logic [31:0]           cpu_rd_data,
    output logic                  cpu_rd_oob,
    output logic [31:0]           pkt_len,
    input  logic                  accept,
    input  logic                  reject,
    output logic                  fwd_valid,
    input  logic [ADDR_WIDTH-1:0] fwd_rd_addr,
    output logic [31:0]           fwd_rd_data,
    input  logic                  fwd_done,
    output logic [31:0]           acc_count,
    output logic [31:0]           rej_count
);

    localparam int IDX_W   = ADDR_WIDTH - 1;
    localparam int LEN_W   = ADDR_WIDTH + 3;
    localparam int BADDR_W = ADDR_WIDTH + 2;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    pb_state_e         state;
    logic [LEN_W-1:0]  len_q;

    assign snp_ready = (state == PB_LOAD);
    assign mem_ready = (state == PB_RUN);
    assign fwd_valid = (state == PB_FWD);
    assign pkt_len   = {{(32-LEN_W){1'b0}}, len_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PB_LOAD;
            len_q     <= '0;
            acc_count <= '0;
            rej_count <= '0;
        end else begin
            case (state)
                PB_LOAD: begin
                    if (snp_done) begin
                        len_q <= snp_len;
                        state <= PB_RUN;
                    end
                end
                PB_RUN: begin
                    if (reject) begin
                        rej_count <= sat_inc(rej_count);
                        len_q     <= '0;
                        state     <= PB_LOAD;
                    end else if (accept) begin
                        acc_count <= sat_inc(acc_count);
                        state     <= PB_FWD;
                    end
                end
                PB_FWD: begin
                    if (fwd_done) begin
                        len_q <= '0;
                        state <= PB_LOAD;
                    end
                end
                default: state <= PB_LOAD;
            endcase
        end
    end

    // Stage p0: bank steering for writes, CPU two-word fetch and OOB compare
    logic                  wr_en_p0;
    logic [IDX_W-1:0]      wr_idx_p0;
    logic [ADDR_WIDTH-1:0] rd_w_p0;
    logic [ADDR_WIDTH-1:0] rd_w1_p0;
    logic [IDX_W-1:0]      even_idx_p0;
    logic [IDX_W-1:0]      odd_idx_p0;
    logic [LEN_W-1:0]      rd_end_p0;
    logic                  oob_p0;

    assign wr_en_p0  = snp_ready && snp_wr_en;
    assign wr_idx_p0 = snp_wr_addr[ADDR_WIDTH-1:1];

    // For an odd w, word w+1 lives in the even bank one row up (wrapping at the top).
    assign rd_w_p0     = cpu_byte_addr[BADDR_W-1:2];
    assign rd_w1_p0    = rd_w_p0 + ADDR_WIDTH'(1);
    assign odd_idx_p0  = rd_w_p0[ADDR_WIDTH-1:1];
    assign even_idx_p0 = rd_w_p0[0] ? rd_w1_p0[ADDR_WIDTH-1:1] : rd_w_p0[ADDR_WIDTH-1:1];

    assign rd_end_p0 = {1'b0, cpu_byte_addr} + LEN_W'(xfer_nbytes(transfer_sz));
    assign oob_p0    = (rd_end_p0 > len_q);

    logic [31:0] even_cpu_p1, odd_cpu_p1, even_fwd_p1, odd_fwd_p1;

    pktbuf_bank #(.IDX_W(IDX_W)) u_bank_even (
        .clk         (clk),
        .wr_en       (wr_en_p0 && !snp_wr_addr[0]),
        .wr_idx      (wr_idx_p0),
        .wr_data     (snp_wr_data),
        .cpu_rd_en   (cpu_rd_en),
        .cpu_rd_idx  (even_idx_p0),
        .cpu_rd_data (even_cpu_p1),
        .fwd_rd_idx  (fwd_rd_addr[ADDR_WIDTH-1:1]),
        .fwd_rd_data (even_fwd_p1)
    );

    pktbuf_bank #(.IDX_W(IDX_W)) u_bank_odd (
        .clk         (clk),
        .wr_en       (wr_en_p0 && snp_wr_addr[0]),
        .wr_idx      (wr_idx_p0),
        .wr_data     (snp_wr_data),
        .cpu_rd_en   (cpu_rd_en),
        .cpu_rd_idx  (odd_idx_p0),
        .cpu_rd_data (odd_cpu_p1),
        .fwd_rd_idx  (fwd_rd_addr[ADDR_WIDTH-1:1]),
        .fwd_rd_data (odd_fwd_p1)
    );

    // Stage p1: read attributes held alongside the bank outputs until the next read
    logic       vld_p1;
    logic       oob_p1;
    logic [1:0] off_p1;
    logic [1:0] sz_p1;
    logic       wsel_p1;
    logic       fwd_vld_p1;
    logic       fwd_sel_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            oob_p1     <= 1'b0;
            off_p1     <= '0;
            sz_p1      <= '0;
            wsel_p1    <= 1'b0;
            fwd_vld_p1 <= 1'b0;
            fwd_sel_p1 <= 1'b0;
        end else begin
            if (cpu_rd_en) begin
                vld_p1  <= 1'b1;
                oob_p1  <= oob_p0;
                off_p1  <= cpu_byte_addr[1:0];
                sz_p1   <= transfer_sz;
                wsel_p1 <= rd_w_p0[0];
            end
            fwd_vld_p1 <= 1'b1;
            fwd_sel_p1 <= fwd_rd_addr[0];
        end
    end

    logic [63:0] pair_p1;
    logic [63:0] shl_p1;
    logic [31:0] aligned_p1;

    assign pair_p1 = wsel_p1 ? {odd_cpu_p1, even_cpu_p1} : {even_cpu_p1, odd_cpu_p1};
    assign shl_p1  = pair_p1 << {off_p1, 3'b000};

    always_comb begin
        aligned_p1 = '0;
        case (sz_p1)
            BPF_W:   aligned_p1 = shl_p1[63:32];
            BPF_H:   aligned_p1 = {16'h0000, shl_p1[63:48]};
            default: aligned_p1 = {24'h000000, shl_p1[63:56]};
        endcase
    end

    assign cpu_rd_oob  = oob_p1;
    assign cpu_rd_data = (vld_p1 && !oob_p1) ? aligned_p1 : 32'h0;
    assign fwd_rd_data = fwd_vld_p1 ? (fwd_sel_p1 ? odd_fwd_p1 : even_fwd_p1) : 32'h0;

endmodule

// File: tb/tb_bpf_pktbuf_ctrl.sv
// Scoreboard bench for bpf_pktbuf_ctrl against a byte-level reference model of the packet.
module tb_bpf_pktbuf_ctrl;

    localparam int AW = 4;
    localparam int NW = 1 << AW;
    localparam int NB = NW * 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          snp_ready;
    logic          snp_wr_en = 1'b0;
    logic [AW-1:0] snp_wr_addr = '0;
    logic [31:0]   snp_wr_data = '0;
    logic          snp_done = 1'b0;
    logic [AW+2:0] snp_len = '0;
    logic          mem_ready;
    logic          cpu_rd_en = 1'b0;
    logic [AW+1:0] cpu_byte_addr = '0;
    logic [1:0]    transfer_sz = '0;
    logic [31:0]   cpu_rd_data;
    logic          cpu_rd_oob;
    logic [31:0]   pkt_len;
    logic          accept = 1'b0;
    logic          reject = 1'b0;
    logic          fwd_valid;
    logic [AW-1:0] fwd_rd_addr = '0;
    logic [31:0]   fwd_rd_data;
    logic          fwd_done = 1'b0;
    logic [31:0]   acc_count;
    logic [31:0]   rej_count;

    bpf_pktbuf_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .snp_ready(snp_ready), .snp_wr_en(snp_wr_en),
        .snp_wr_addr(snp_wr_addr), .snp_wr_data(snp_wr_data), .snp_done(snp_done),
        .snp_len(snp_len), .mem_ready(mem_ready), .cpu_rd_en(cpu_rd_en),
        .cpu_byte_addr(cpu_byte_addr), .transfer_sz(transfer_sz), .cpu_rd_data(cpu_rd_data),
        .cpu_rd_oob(cpu_rd_oob), .pkt_len(pkt_len), .accept(accept), .reject(reject),
        .fwd_valid(fwd_valid), .fwd_rd_addr(fwd_rd_addr), .fwd_rd_data(fwd_rd_data),
        .fwd_done(fwd_done), .acc_count(acc_count), .rej_count(rej_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] ref_mem [NW];
    int          ref_len = 0;
    int          ref_acc = 0;
    int          ref_rej = 0;

    logic [32:0] cpu_q [$];
    logic [31:0] fwd_q [$];
    logic        fwd_chk = 1'b0;
    logic        cpu_en_d = 1'b0;
    logic        fwd_chk_d = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: a strobe seen at a rising edge has its response visible by the falling edge.
    always @(posedge clk) begin
        cpu_en_d  <= cpu_rd_en;
        fwd_chk_d <= fwd_chk;
    end

    always @(negedge clk) begin
        if (cpu_en_d) begin
            if (cpu_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL cpu_read: response with no expectation queued");
            end else begin
                logic [32:0] e;
                e = cpu_q.pop_front();
                check("cpu_rd_oob", 32'(cpu_rd_oob), 32'(e[32]));
                check("cpu_rd_data", cpu_rd_data, e[31:0]);
            end
        end
        if (fwd_chk_d) begin
            if (fwd_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL fwd_read: response with no expectation queued");
            end else begin
                logic [31:0] f;
                f = fwd_q.pop_front();
                check("fwd_rd_data", fwd_rd_data, f);
            end
        end
    end

    // Big-endian byte view of the buffer: byte x is byte x%4 of word x/4, addresses wrap.
    function automatic logic [32:0] ref_read(input int b, input int sz);
        int n;
        logic [31:0] d;
        n = (sz == 0) ? 4 : (sz == 1) ? 2 : 1;
        if (b + n > ref_len) return {1'b1, 32'h0};
        d = 32'h0;
        for (int k = 0; k < n; k++) begin
            int x;
            x = (b + k) % NB;
            d = (d << 8) | ((ref_mem[x / 4] >> (8 * (3 - (x % 4)))) & 32'hFF);
        end
        return {1'b0, d};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        snp_wr_en = 1'b0;
        snp_done  = 1'b0;
        cpu_rd_en = 1'b0;
        accept    = 1'b0;
        reject    = 1'b0;
        fwd_done  = 1'b0;
        fwd_chk   = 1'b0;
    endtask

    task automatic issue_read(input int b, input int sz);
        cpu_rd_en     = 1'b1;
        cpu_byte_addr = (AW+2)'(b);
        transfer_sz   = 2'(sz);
        cpu_q.push_back(ref_read(b, sz));
    endtask

    task automatic issue_read_exp(input int b, input int sz, input logic [32:0] e);
        cpu_rd_en     = 1'b1;
        cpu_byte_addr = (AW+2)'(b);
        transfer_sz   = 2'(sz);
        cpu_q.push_back(e);
    endtask

    task automatic issue_fwd(input int w, input logic [31:0] e);
        fwd_rd_addr = AW'(w);
        fwd_chk     = 1'b1;
        fwd_q.push_back(e);
    endtask

    task automatic drive_write(input int w, input logic [31:0] d);
        snp_wr_en   = 1'b1;
        snp_wr_addr = AW'(w);
        snp_wr_data = d;
    endtask

    task automatic random_packet();
        int nwr, len;
        nwr = $urandom_range(1, 20);
        len = $urandom_range(0, 127);
        for (int i = 0; i < nwr; i++) begin
            int w;
            logic [31:0] d;
            w = $urandom_range(0, NW - 1);
            d = $urandom;
            if ($urandom_range(0, 3) == 0)
                issue_read($urandom_range(0, NB - 1), $urandom_range(0, 3));
            drive_write(w, d);
            if (i == nwr - 1) begin
                snp_done = 1'b1;
                snp_len  = 7'(len);
            end
            ref_mem[w] = d;
            cyc();
        end
        ref_len = len;
        check("mem_ready_after_load", 32'(mem_ready), 32'd1);
        check("pkt_len_after_load", pkt_len, 32'(len));
    endtask

    initial begin
        for (int i = 0; i < NW; i++) ref_mem[i] = 32'h0;

        cyc();
        cyc();
        check("rst_snp_ready", 32'(snp_ready), 32'd1);
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        check("rst_pkt_len", pkt_len, 32'd0);
        check("rst_acc_count", acc_count, 32'd0);
        check("rst_rej_count", rej_count, 32'd0);
        check("rst_cpu_rd_data", cpu_rd_data, 32'd0);
        check("rst_cpu_rd_oob", 32'(cpu_rd_oob), 32'd0);
        check("rst_fwd_rd_data", fwd_rd_data, 32'd0);
        rst = 1'b0;

        // Directed packet: three known words plus random fill, done on the last write.
        for (int i = 0; i < NW; i++) begin
            logic [31:0] d;
            d = (i == 0) ? 32'h01020304 : (i == 1) ? 32'h05060708 :
                (i == 2) ? 32'h090A0000 : 32'($urandom);
            drive_write(i, d);
            ref_mem[i] = d;
            if (i == NW - 1) begin
                snp_done = 1'b1;
                snp_len  = 7'd10;
            end
            cyc();
        end
        ref_len = 10;
        check("dir_mem_ready", 32'(mem_ready), 32'd1);
        check("dir_snp_ready", 32'(snp_ready), 32'd0);
        check("dir_pkt_len", pkt_len, 32'd10);

        issue_read_exp(1, 0, {1'b0, 32'h02030405}); cyc();
        issue_read_exp(8, 1, {1'b0, 32'h0000090A}); cyc();
        issue_read_exp(9, 2, {1'b0, 32'h0000000A}); cyc();
        issue_read_exp(8, 0, {1'b1, 32'h00000000}); cyc();
        issue_read_exp(7, 3, {1'b0, 32'h00000008}); cyc();

        drive_write(0, 32'hDEADBEEF); cyc();
        issue_read_exp(0, 0, {1'b0, 32'h01020304}); cyc();

        accept = 1'b1; cyc();
        ref_acc++;
        check("acc_mem_ready", 32'(mem_ready), 32'd0);
        check("acc_fwd_valid", 32'(fwd_valid), 32'd1);
        check("acc_count_1", acc_count, 32'd1);
        issue_fwd(1, 32'h05060708); cyc();

        accept = 1'b1; reject = 1'b1; cyc();
        check("fwd_ignores_verdict_rej", rej_count, 32'd0);
        check("fwd_ignores_verdict_acc", acc_count, 32'd1);
        check("fwd_still_valid", 32'(fwd_valid), 32'd1);

        fwd_done = 1'b1; cyc();
        ref_len = 0;
        check("fwd_done_snp_ready", 32'(snp_ready), 32'd1);
        check("fwd_done_pkt_len", pkt_len, 32'd0);

        accept = 1'b1; cyc();
        check("load_ignores_accept", acc_count, 32'd1);
        check("load_stays_load", 32'(snp_ready), 32'd1);

        drive_write(0, 32'hCAFEF00D); ref_mem[0] = 32'hCAFEF00D;
        snp_done = 1'b1; snp_len = 7'd12; cyc();
        ref_len = 12;
        accept = 1'b1; reject = 1'b1; cyc();
        ref_rej++; ref_len = 0;
        check("both_snp_ready", 32'(snp_ready), 32'd1);
        check("both_mem_ready", 32'(mem_ready), 32'd0);
        check("both_rej_count", rej_count, 32'd1);
        check("both_acc_count", acc_count, 32'd1);

        for (int p = 0; p < 40; p++) begin
            int v, nrd;
            random_packet();
            nrd = $urandom_range(4, 14);
            for (int r = 0; r < nrd; r++) begin
                if ($urandom_range(0, 3) == 0) drive_write($urandom_range(0, NW - 1), $urandom);
                issue_read($urandom_range(0, NB - 1), $urandom_range(0, 3));
                cyc();
            end
            v = $urandom_range(0, 2);
            if (v == 0) begin
                accept = 1'b1; cyc();
                ref_acc++;
                check("rnd_fwd_valid", 32'(fwd_valid), 32'd1);
                check("rnd_acc_count", acc_count, 32'(ref_acc));
                for (int r = 0; r < 4; r++) begin
                    int w;
                    w = $urandom_range(0, NW - 1);
                    issue_fwd(w, ref_mem[w]);
                    if (r == 3) fwd_done = 1'b1;
                    cyc();
                end
                ref_len = 0;
            end else begin
                reject = 1'b1;
                accept = (v == 2);
                cyc();
                ref_rej++; ref_len = 0;
                check("rnd_acc_count_rej", acc_count, 32'(ref_acc));
                check("rnd_rej_count", rej_count, 32'(ref_rej));
            end
            check("rnd_back_to_load", 32'(snp_ready), 32'd1);
            check("rnd_pkt_len_cleared", pkt_len, 32'd0);
        end

        random_packet();
        cyc();
        rst = 1'b1; cyc();
        rst = 1'b0;
        check("rst_run_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_run_snp_ready", 32'(snp_ready), 32'd1);
        check("rst_run_acc_count", acc_count, 32'd0);
        check("rst_run_rej_count", rej_count, 32'd0);
        check("rst_run_pkt_len", pkt_len, 32'd0);

        cyc();
        cyc();
        if (cpu_q.size() != 0 || fwd_q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard_drain: cpu %0d fwd %0d left, expected 0 0", cpu_q.size(), fwd_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
